// File: rtl/quant_cfu_pkg.sv
// Shared types and constants for the quant CFU sequencer.
// CFU command codes, sequencer states and the int8 range test.
package quant_cfu_pkg;

  localparam int INT32_SIZE = 32;
  localparam int BYTE_SIZE  = 8;

  typedef enum logic [6:0] {
    CMD_RESET   = 7'd0,
    CMD_BIAS    = 7'd1,
    CMD_MULT    = 7'd2,
    CMD_SHIFT   = 7'd3,
    CMD_ACT_MIN = 7'd4,
    CMD_ACT_MAX = 7'd5,
    CMD_OFFSET  = 7'd6,
    CMD_QUANT   = 7'd7
  } cfu_cmd_e;

  typedef enum logic [1:0] {
    IDLE,
    CFG,
    RUN,
    DRAIN
  } seq_state_e;

  // hi is ret[31:7]; the value fits int8 when all these bits agree
  function automatic logic fits_int8(input logic [24:0] hi);
    return (&hi) || ~(|hi);
  endfunction

endpackage

// File: rtl/quant_seq_fifo.sv
// First-word-fall-through sync FIFO for packed output words.
// Data reads as zero while empty.
module quant_seq_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   free
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_pop;
  logic             full;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign free     = CW'(DEPTH) - count;
  assign do_pop   = pop && !empty;
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= nxt(wr_ptr);
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      unique case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n) !(push && full)
  );

endmodule

// File: rtl/quant_cfu_sequencer.sv
// Drives the quant CFU: writes one parameter set, then streams
// accumulators through CMD_QUANT and packs int8 results per word.
module quant_cfu_sequencer
  import quant_cfu_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [INT32_SIZE-1:0]   cfg_bias,
  input  logic [INT32_SIZE-1:0]   cfg_mult,
  input  logic [INT32_SIZE-1:0]   cfg_shift,
  input  logic [INT32_SIZE-1:0]   cfg_act_min,
  input  logic [INT32_SIZE-1:0]   cfg_act_max,
  input  logic [INT32_SIZE-1:0]   cfg_offset,
  input  logic                    acc_valid,
  output logic                    acc_ready,
  input  logic [INT32_SIZE-1:0]   acc_data,
  input  logic                    acc_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [8*LANES-1:0]      out_data,
  output logic [LANES-1:0]        out_keep,
  output logic                    out_last,
  output logic [6:0]              cfu_cmd,
  output logic [INT32_SIZE-1:0]   cfu_inp0,
  output logic [INT32_SIZE-1:0]   cfu_inp1,
  input  logic [INT32_SIZE-1:0]   cfu_ret,
  output logic                    busy,
  output logic                    sat_err
);

  localparam int OW = BYTE_SIZE*LANES;
  localparam int FW = OW+LANES+1;
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW = $clog2(OUT_DEPTH+1);

  seq_state_e state;
  seq_state_e state_nx;
  cfu_cmd_e   cmd_nx;
  logic [INT32_SIZE-1:0] inp1_nx;

  logic [2:0]                  cfg_idx;
  logic [6:1][INT32_SIZE-1:0]  param;
  logic                        last_seen;

  logic iss_v, iss_last;
  logic ret_v, ret_last;

  logic [OW-1:0]    pk_data, data_nx;
  logic [LANES-1:0] pk_keep, keep_nx;
  logic [LW-1:0]    pk_lane;

  logic          push;
  logic [FW-1:0] push_data, pop_data;
  logic          empty;
  logic [CW-1:0] free;

  logic cfg_fire, acc_fire, drained;

  assign cfg_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign acc_ready = (state == RUN) && (free >= CW'(2)) && !last_seen;
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign acc_fire  = acc_valid && acc_ready;
  assign drained   = !iss_v && !ret_v && (pk_keep == '0) && empty;

  always_comb begin
    state_nx = state;
    cmd_nx   = CMD_RESET;
    inp1_nx  = '0;
    unique case (state)
      IDLE: if (cfg_fire) state_nx = CFG;
      CFG: begin
        cmd_nx  = cfu_cmd_e'({4'd0, cfg_idx});
        inp1_nx = param[cfg_idx];
        if (cfg_idx == 3'd6) state_nx = RUN;
      end
      RUN: if (acc_fire) begin
        cmd_nx  = CMD_QUANT;
        inp1_nx = acc_data;
        if (acc_last) state_nx = DRAIN;
      end
      DRAIN: if (drained) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cfu_cmd   <= '0;
      cfu_inp0  <= '0;
      cfu_inp1  <= '0;
      cfg_idx   <= '0;
      param     <= '0;
      last_seen <= 1'b0;
      sat_err   <= 1'b0;
    end else begin
      state    <= state_nx;
      cfu_cmd  <= cmd_nx;
      cfu_inp0 <= '0;
      cfu_inp1 <= inp1_nx;
      if (cfg_fire) begin
        param <= {cfg_offset, cfg_act_max, cfg_act_min,
                  cfg_shift, cfg_mult, cfg_bias};
        cfg_idx   <= 3'd1;
        last_seen <= 1'b0;
        sat_err   <= 1'b0;
      end else begin
        if (state == CFG) cfg_idx <= cfg_idx + 1'b1;
        if (acc_fire && acc_last) last_seen <= 1'b1;
        if (ret_v && !fits_int8(cfu_ret[31:7])) sat_err <= 1'b1;
      end
    end
  end

  // CFU ret is valid two edges after the accepting edge
  assign data_nx   = pk_data | (OW'(cfu_ret[7:0]) << (BYTE_SIZE*pk_lane));
  assign keep_nx   = pk_keep | (LANES'(1) << pk_lane);
  assign push      = ret_v && (ret_last || pk_lane == LW'(LANES-1));
  assign push_data = {ret_last, keep_nx, data_nx};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_v    <= 1'b0;
      iss_last <= 1'b0;
      ret_v    <= 1'b0;
      ret_last <= 1'b0;
      pk_data  <= '0;
      pk_keep  <= '0;
      pk_lane  <= '0;
    end else begin
      iss_v    <= acc_fire;
      iss_last <= acc_fire && acc_last;
      ret_v    <= iss_v;
      ret_last <= iss_last;
      if (ret_v) begin
        if (push) begin
          pk_data <= '0;
          pk_keep <= '0;
          pk_lane <= '0;
        end else begin
          pk_data <= data_nx;
          pk_keep <= keep_nx;
          pk_lane <= pk_lane + 1'b1;
        end
      end
    end
  end

  quant_seq_fifo #(
    .WIDTH (FW),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (out_ready),
    .pop_data  (pop_data),
    .empty     (empty),
    .free      (free)
  );

  assign out_valid = !empty;
  assign {out_last, out_keep, out_data} = pop_data;

endmodule

// File: tb/tb_quant_cfu_sequencer.sv
// Bench for quant_cfu_sequencer with a behavioural quant CFU partner
// and a word-level expectation queue built from each stream.
module tb_quant_cfu_sequencer;

  localparam int LANES     = 4;
  localparam int OUT_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] cfg_bias = '0, cfg_mult = '0, cfg_shift = '0;
  logic [31:0] cfg_act_min = '0, cfg_act_max = '0, cfg_offset = '0;
  logic        acc_valid = 1'b0;
  logic        acc_ready;
  logic [31:0] acc_data = '0;
  logic        acc_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_last;
  logic [6:0]  cfu_cmd;
  logic [31:0] cfu_inp0, cfu_inp1;
  logic [31:0] cfu_ret;
  logic        busy, sat_err;

  quant_cfu_sequencer #(.LANES(LANES), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_bias(cfg_bias), .cfg_mult(cfg_mult), .cfg_shift(cfg_shift),
    .cfg_act_min(cfg_act_min), .cfg_act_max(cfg_act_max),
    .cfg_offset(cfg_offset),
    .acc_valid(acc_valid), .acc_ready(acc_ready),
    .acc_data(acc_data), .acc_last(acc_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
    .cfu_cmd(cfu_cmd), .cfu_inp0(cfu_inp0), .cfu_inp1(cfu_inp1),
    .cfu_ret(cfu_ret), .busy(busy), .sat_err(sat_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } word_t;

  word_t exp_q[$];
  word_t got_q[$];
  int    acc_cyc[$];
  bit    saw_stall = 0;
  int    m_bias, m_mult, m_shift, m_min, m_max, m_off;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic flag_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // Fixed-point requantisation: left shift, Q31 multiply, offset, clamp
  function automatic int quant(input int acc, input int bias,
                               input int mult, input int shift,
                               input int mn, input int mx, input int off);
    longint x, y;
    x = longint'(acc) + longint'(bias);
    x = (shift >= 0) ? (x <<< shift) : (x >>> (-shift));
    y = (x * longint'(mult) + (longint'(1) <<< 30)) >>> 31;
    y = y + longint'(off);
    if (y < longint'(mn)) y = longint'(mn);
    if (y > longint'(mx)) y = longint'(mx);
    return int'(y);
  endfunction

  int c_bias, c_mult, c_shift, c_min, c_max, c_off;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_bias <= 0; c_mult <= 0; c_shift <= 0;
      c_min <= 0; c_max <= 0; c_off <= 0;
      cfu_ret <= '0;
    end else begin
      cfu_ret <= '0;
      case (cfu_cmd)
        7'd1: c_bias  <= int'(cfu_inp1);
        7'd2: c_mult  <= int'(cfu_inp1);
        7'd3: c_shift <= int'(cfu_inp1);
        7'd4: c_min   <= int'(cfu_inp1);
        7'd5: c_max   <= int'(cfu_inp1);
        7'd6: c_off   <= int'(cfu_inp1);
        7'd7: cfu_ret <= quant(int'(cfu_inp1), c_bias, c_mult,
                               c_shift, c_min, c_max, c_off);
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin : cmp
    word_t e;
    if (rst_n && out_valid && out_ready) begin
      e.data = out_data;
      e.keep = out_keep;
      e.last = out_last;
      got_q.push_back(e);
      if (exp_q.size() == 0) begin
        flag_fail("unexpected_word");
      end else begin
        e = exp_q.pop_front();
        check("out_data", out_data, e.data);
        check("out_keep", {28'd0, out_keep}, {28'd0, e.keep});
        check("out_last", {31'd0, out_last}, {31'd0, e.last});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && acc_valid && acc_ready) acc_cyc.push_back(cyc);
    if (rst_n && acc_valid && !acc_ready && !out_ready) saw_stall = 1;
  end

  task automatic push_stream(input int a[$]);
    for (int i = 0; i < a.size(); i += LANES) begin
      word_t w;
      w.data = '0;
      w.keep = '0;
      for (int l = 0; l < LANES; l++) begin
        if (i + l < a.size()) begin
          int r;
          r = quant(a[i+l], m_bias, m_mult, m_shift, m_min, m_max, m_off);
          w.data[l*8 +: 8] = r[7:0];
          w.keep[l] = 1'b1;
        end
      end
      w.last = (i + LANES >= a.size());
      exp_q.push_back(w);
    end
  endtask

  task automatic send(input int v, input bit last);
    int t = 0;
    acc_valid = 1'b1;
    acc_data  = v;
    acc_last  = last;
    @(negedge clk);
    while (!acc_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!acc_ready) flag_fail("acc_accept_timeout");
    @(posedge clk);
    #1;
    acc_valid = 1'b0;
    acc_last  = 1'b0;
  endtask

  task automatic send_stream(input int a[$], input bit tag_last);
    acc_cyc.delete();
    for (int i = 0; i < a.size(); i++)
      send(a[i], tag_last && (i == a.size() - 1));
  endtask

  task automatic do_cfg(input int b, input int m, input int s,
                        input int mn, input int mx, input int o);
    int p[6];
    int t = 0;
    p = '{b, m, s, mn, mx, o};
    cfg_bias = b; cfg_mult = m; cfg_shift = s;
    cfg_act_min = mn; cfg_act_max = mx; cfg_offset = o;
    cfg_valid = 1'b1;
    @(negedge clk);
    while (!cfg_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!cfg_ready) flag_fail("cfg_ready_timeout");
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    m_bias = b; m_mult = m; m_shift = s;
    m_min = mn; m_max = mx; m_off = o;
    t = 0;
    @(negedge clk);
    while (cfu_cmd != 7'd1 && t < 8) begin
      @(negedge clk);
      t++;
    end
    if (cfu_cmd != 7'd1) flag_fail("cfg_cmd_start");
    check("cfg_inp0", cfu_inp0, 32'd0);
    for (int k = 1; k <= 6; k++) begin
      check("cfg_cmd", {25'd0, cfu_cmd}, k);
      check("cfg_val", cfu_inp1, p[k-1]);
      if (k < 6) @(negedge clk);
    end
    t = 0;
    while (!acc_ready && t < 3) begin
      @(negedge clk);
      t++;
    end
    check("cfg_acc_ready", {31'd0, acc_ready}, 32'd1);
    check("cfg_sat_clear", {31'd0, sat_err}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (!(cfg_ready && exp_q.size() == 0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) flag_fail("idle_timeout");
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_exp_empty", exp_q.size(), 32'd0);
    check("idle_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cfg_ready"}, {31'd0, cfg_ready}, 32'd1);
    check({tag, "_acc_ready"}, {31'd0, acc_ready}, 32'd0);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_out_data"}, out_data, 32'd0);
    check({tag, "_out_keep"}, {28'd0, out_keep}, 32'd0);
    check({tag, "_out_last"}, {31'd0, out_last}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_sat_err"}, {31'd0, sat_err}, 32'd0);
    check({tag, "_cmd"}, {25'd0, cfu_cmd}, 32'd0);
    check({tag, "_inp0"}, cfu_inp0, 32'd0);
    check({tag, "_inp1"}, cfu_inp1, 32'd0);
  endtask

  localparam int MULT_HALF = 32'h4000_0000;

  initial begin
    int s1[$];
    int s2[$];
    int s3[$];
    int s4[$];
    int s5[$];
    s1 = '{1, -2, 3, -4, 5, -6, 7, -8};
    s2 = '{10, 20, 30, 40, 50};
    for (int i = 0; i < 16; i++) s3.push_back(i*7 - 50);
    s4 = '{300};
    s5 = '{1, 2, 3, 4, 5, 6};

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_cfg(0, MULT_HALF, 1, -128, 127, 0);
    got_q.delete();
    push_stream(s1);
    send_stream(s1, 1'b1);
    check("s1_accepts", acc_cyc.size(), 32'd8);
    if (acc_cyc.size() == 8)
      check("s1_back_to_back", acc_cyc[7] - acc_cyc[0], 32'd7);
    wait_idle();
    check("s1_words", got_q.size(), 32'd2);
    if (got_q.size() == 2) begin
      check("s1_w0", got_q[0].data, 32'hFC03FE01);
      check("s1_w0_keep", {28'd0, got_q[0].keep}, 32'hF);
      check("s1_w1", got_q[1].data, 32'hF807FA05);
      check("s1_w1_last", {31'd0, got_q[1].last}, 32'd1);
    end

    do_cfg(0, MULT_HALF, 1, -128, 127, 0);
    got_q.delete();
    push_stream(s2);
    send_stream(s2, 1'b1);
    wait_idle();
    check("s2_words", got_q.size(), 32'd2);
    if (got_q.size() == 2) begin
      check("s2_w0", got_q[0].data, 32'h281E140A);
      check("s2_w1", got_q[1].data, 32'h00000032);
      check("s2_w1_keep", {28'd0, got_q[1].keep}, 32'h1);
      check("s2_w1_last", {31'd0, got_q[1].last}, 32'd1);
    end
    check("s2_cfg_ready", {31'd0, cfg_ready}, 32'd1);

    do_cfg(0, MULT_HALF, 1, -128, 127, 0);
    got_q.delete();
    out_ready = 1'b0;
    saw_stall = 0;
    push_stream(s3);
    fork
      send_stream(s3, 1'b1);
      begin
        repeat (20) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_idle();
    check("bp_stall_seen", {31'd0, saw_stall}, 32'd1);
    check("bp_words", got_q.size(), 32'd4);

    do_cfg(0, MULT_HALF, 1, -128, 1000, 0);
    got_q.delete();
    push_stream(s4);
    send_stream(s4, 1'b1);
    wait_idle();
    check("sat_err_set", {31'd0, sat_err}, 32'd1);
    if (got_q.size() == 1)
      check("sat_lane", got_q[0].data, 32'h0000002C);
    else
      flag_fail("sat_word_count");
    repeat (5) @(posedge clk);
    #1;
    check("sat_err_sticky", {31'd0, sat_err}, 32'd1);
    do_cfg(0, MULT_HALF, 1, -128, 127, 0);

    out_ready = 1'b0;
    send_stream(s5, 1'b0);
    check("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    do_cfg(0, MULT_HALF, 1, -128, 127, 0);
    got_q.delete();
    push_stream(s1);
    send_stream(s1, 1'b1);
    wait_idle();
    check("post_rst_words", got_q.size(), 32'd2);
    if (got_q.size() == 2) begin
      check("post_rst_w0", got_q[0].data, 32'hFC03FE01);
      check("post_rst_w1", got_q[1].data, 32'hF807FA05);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
